// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter sharing the three HEX digits between two 12-bit requesters,
// with a minimum dwell per grant and registered seven-segment decode.
module hex_display_arbiter #(
  parameter int DWELL = 50_000_000
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [1:0]  REQ,
  input  logic [11:0] VAL0,
  input  logic [11:0] VAL1,
  output logic [1:0]  GNT,
  output logic        BUSY,
  output logic [7:0]  HEX0,
  output logic [7:0]  HEX1,
  output logic [7:0]  HEX2
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, SHOW0, SHOW1} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_last, w_last_nxt;
  logic [1:0]       r_gnt, w_gnt_nxt;
  logic             r_busy;
  logic [7:0]       r_hex0, r_hex1, r_hex2;
  logic [7:0]       w_hex0, w_hex1, w_hex2;

  // Active-low segments, DP (bit 7) always off.
  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
      4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
      4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
      4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
    endcase
    return s;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    unique case (r_state)
      IDLE: begin
        case (REQ)
          2'b01:   w_state_nxt = SHOW0;
          2'b10:   w_state_nxt = SHOW1;
          2'b11:   w_state_nxt = r_last ? SHOW0 : SHOW1;
          default: w_state_nxt = IDLE;
        endcase
      end
      SHOW0: begin
        if (r_cnt != '0)  w_cnt_nxt   = r_cnt - CNT_W'(1);
        else if (REQ[1])  w_state_nxt = SHOW1;
        else if (REQ[0])  w_cnt_nxt   = RELOAD;
        else              w_state_nxt = IDLE;
      end
      SHOW1: begin
        if (r_cnt != '0)  w_cnt_nxt   = r_cnt - CNT_W'(1);
        else if (REQ[0])  w_state_nxt = SHOW0;
        else if (REQ[1])  w_cnt_nxt   = RELOAD;
        else              w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    // A fresh grant (from IDLE or a handover) restarts the dwell and moves the pointer.
    if ((w_state_nxt != r_state) && (w_state_nxt != IDLE)) begin
      w_cnt_nxt  = RELOAD;
      w_last_nxt = (w_state_nxt == SHOW1);
    end
  end

  // Outputs follow the next state so grant and displayed digits switch together.
  always_comb begin
    w_gnt_nxt = 2'b00;
    w_hex0    = 8'hFF;
    w_hex1    = 8'hFF;
    w_hex2    = 8'hFF;
    case (w_state_nxt)
      SHOW0: begin
        w_gnt_nxt = 2'b01;
        w_hex2    = seg_decode(VAL0[11:8]);
        w_hex1    = seg_decode(VAL0[7:4]);
        w_hex0    = seg_decode(VAL0[3:0]);
      end
      SHOW1: begin
        w_gnt_nxt = 2'b10;
        w_hex2    = seg_decode(VAL1[11:8]);
        w_hex1    = seg_decode(VAL1[7:4]);
        w_hex0    = seg_decode(VAL1[3:0]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_gnt   <= 2'b00;
      r_busy  <= 1'b0;
      r_hex0  <= 8'hFF;
      r_hex1  <= 8'hFF;
      r_hex2  <= 8'hFF;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
      r_gnt   <= w_gnt_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_hex0  <= w_hex0;
      r_hex1  <= w_hex1;
      r_hex2  <= w_hex2;
    end
  end

  assign GNT  = r_gnt;
  assign BUSY = r_busy;
  assign HEX0 = r_hex0;
  assign HEX1 = r_hex1;
  assign HEX2 = r_hex2;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Scenario bench for hex_display_arbiter: DWELL=4 main instance plus a DWELL=1 instance.
module tb_hex_display_arbiter;

  logic        CLOCK_50;
  logic        RESET_N;
  logic [1:0]  REQ;
  logic [11:0] VAL0, VAL1;
  logic [1:0]  g4, g1;
  logic        b4, b1;
  logic [7:0]  h4_0, h4_1, h4_2, h1_0, h1_1, h1_2;

  int n_checks = 0;
  int n_errors = 0;
  logic [26:0] q[$];
  logic [26:0] e, o;

  logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  hex_display_arbiter #(.DWELL(4)) u_dut4 (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .REQ(REQ), .VAL0(VAL0), .VAL1(VAL1),
    .GNT(g4), .BUSY(b4), .HEX0(h4_0), .HEX1(h4_1), .HEX2(h4_2));

  hex_display_arbiter #(.DWELL(1)) u_dut1 (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .REQ(REQ), .VAL0(VAL0), .VAL1(VAL1),
    .GNT(g1), .BUSY(b1), .HEX0(h1_0), .HEX1(h1_1), .HEX2(h1_2));

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Expected {GNT, BUSY, HEX2, HEX1, HEX0} for a grant showing value v.
  function automatic logic [26:0] exp_word(input logic [1:0] gnt, input logic [11:0] v);
    logic [3:0] n2, n1, n0;
    n2 = v[11:8]; n1 = v[7:4]; n0 = v[3:0];
    if (gnt == 2'b00) return {2'b00, 1'b0, 24'hFFFFFF};
    return {gnt, 1'b1, SEG[n2], SEG[n1], SEG[n0]};
  endfunction

  function automatic logic [11:0] sel_val(input logic [1:0] gnt);
    return (gnt == 2'b10) ? VAL1 : VAL0;
  endfunction

  task automatic do_reset();
    RESET_N = 1'b0; REQ = 2'b00; VAL0 = 12'h000; VAL1 = 12'h000;
    repeat (2) @(posedge CLOCK_50);
    #1 RESET_N = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    q.push_back(exp_word(2'b00, 12'h000));
    e = q.pop_front(); n_checks++;
    if ({g4, b4, h4_2, h4_1, h4_0} !== e) begin
      n_errors++; $display("FAIL reset_state got %h exp %h", {g4, b4, h4_2, h4_1, h4_0}, e);
    end
    n_checks++;
    if ({g1, b1, h1_2, h1_1, h1_0} !== e) begin
      n_errors++; $display("FAIL reset_state_d1 got %h exp %h", {g1, b1, h1_2, h1_1, h1_0}, e);
    end
    REQ = 2'b10; VAL1 = 12'h5E1;
    for (int i = 0; i < 2; i++) begin
      q.push_back(exp_word(2'b10, VAL1));
      @(posedge CLOCK_50); #1;
      e = q.pop_front(); n_checks++;
      if ({g4, b4, h4_2, h4_1, h4_0} !== e) begin
        n_errors++; $display("FAIL reset_pre_show1 cyc %0d got %h exp %h", i, {g4, b4, h4_2, h4_1, h4_0}, e);
      end
    end
    RESET_N = 1'b0;
    q.push_back(exp_word(2'b00, 12'h000));
    #1;
    e = q.pop_front(); n_checks++;
    if ({g4, b4, h4_2, h4_1, h4_0} !== e) begin
      n_errors++; $display("FAIL reset_async got %h exp %h", {g4, b4, h4_2, h4_1, h4_0}, e);
    end
    REQ = 2'b11; VAL0 = 12'h3A7;
    #1 RESET_N = 1'b1;
    q.push_back(exp_word(2'b01, VAL0));
    @(posedge CLOCK_50); #1;
    e = q.pop_front(); n_checks++;
    if ({g4, b4, h4_2, h4_1, h4_0} !== e) begin
      n_errors++; $display("FAIL reset_release_grant got %h exp %h", {g4, b4, h4_2, h4_1, h4_0}, e);
    end
  endtask

  task automatic test_single();
    logic [1:0] eg;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      REQ = 2'b01;
      VAL0 = (i < 5) ? 12'h3A7 : 12'h0F2;
      eg = 2'b01;
      q.push_back((i == 0) ? {2'b01, 1'b1, 8'hB0, 8'h88, 8'hF8} : exp_word(eg, sel_val(eg)));
      @(posedge CLOCK_50); #1;
      e = q.pop_front(); n_checks++;
      if ({g4, b4, h4_2, h4_1, h4_0} !== e) begin
        n_errors++; $display("FAIL single cyc %0d got %h exp %h", i, {g4, b4, h4_2, h4_1, h4_0}, e);
      end
    end
  endtask

  task automatic test_contention();
    logic [1:0] eg;
    do_reset();
    VAL1 = 12'hC5E;
    for (int i = 0; i < 12; i++) begin
      REQ = 2'b11;
      VAL0 = (i < 2) ? 12'h3A7 : 12'h9B4;
      eg = (i < 4 || i >= 8) ? 2'b01 : 2'b10;
      q.push_back(exp_word(eg, sel_val(eg)));
      @(posedge CLOCK_50); #1;
      e = q.pop_front(); n_checks++;
      if ({g4, b4, h4_2, h4_1, h4_0} !== e) begin
        n_errors++; $display("FAIL contention cyc %0d got %h exp %h", i, {g4, b4, h4_2, h4_1, h4_0}, e);
      end
    end
  endtask

  task automatic test_early_drop();
    logic [1:0] eg;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      REQ = (i == 0) ? 2'b01 : 2'b00;
      VAL0 = (i < 2) ? 12'h1D8 : 12'hE6C;
      eg = (i < 4) ? 2'b01 : 2'b00;
      q.push_back(exp_word(eg, sel_val(eg)));
      @(posedge CLOCK_50); #1;
      e = q.pop_front(); n_checks++;
      if ({g4, b4, h4_2, h4_1, h4_0} !== e) begin
        n_errors++; $display("FAIL early_drop cyc %0d got %h exp %h", i, {g4, b4, h4_2, h4_1, h4_0}, e);
      end
    end
  endtask

  task automatic test_fairness();
    logic [1:0] eg;
    do_reset();
    VAL0 = 12'h246; VAL1 = 12'hACE;
    for (int i = 0; i < 10; i++) begin
      REQ = (i == 0) ? 2'b01 : ((i < 5) ? 2'b00 : 2'b11);
      eg = (i < 4) ? 2'b01 : (i == 4) ? 2'b00 : (i < 9) ? 2'b10 : 2'b01;
      q.push_back(exp_word(eg, sel_val(eg)));
      @(posedge CLOCK_50); #1;
      e = q.pop_front(); n_checks++;
      if ({g4, b4, h4_2, h4_1, h4_0} !== e) begin
        n_errors++; $display("FAIL fairness cyc %0d got %h exp %h", i, {g4, b4, h4_2, h4_1, h4_0}, e);
      end
    end
  endtask

  task automatic test_decode_sweep();
    logic [7:0] s;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      REQ = 2'b01;
      VAL0 = 12'(i * 12'h111);
      s = SEG[i];
      q.push_back({2'b01, 1'b1, s, s, s});
      @(posedge CLOCK_50); #1;
      e = q.pop_front(); n_checks++;
      if (({g4, b4, h4_2, h4_1, h4_0} !== e) || (h4_0[7] !== 1'b1)) begin
        n_errors++; $display("FAIL decode_sweep digit %0d got %h exp %h", i, {g4, b4, h4_2, h4_1, h4_0}, e);
      end
    end
  endtask

  task automatic test_dwell1();
    logic [1:0] eg;
    do_reset();
    VAL0 = 12'h8F0; VAL1 = 12'h17B;
    for (int i = 0; i < 8; i++) begin
      REQ = (i < 4) ? 2'b11 : ((i < 6) ? 2'b01 : 2'b00);
      eg = (i < 4) ? ((i % 2 == 0) ? 2'b01 : 2'b10) : ((i < 6) ? 2'b01 : 2'b00);
      q.push_back(exp_word(eg, sel_val(eg)));
      @(posedge CLOCK_50); #1;
      e = q.pop_front(); n_checks++;
      if ({g1, b1, h1_2, h1_1, h1_0} !== e) begin
        n_errors++; $display("FAIL dwell1 cyc %0d got %h exp %h", i, {g1, b1, h1_2, h1_1, h1_0}, e);
      end
    end
  endtask

  initial begin
    RESET_N = 1'b0; REQ = 2'b00; VAL0 = 12'h000; VAL1 = 12'h000;
    test_reset();
    test_single();
    test_contention();
    test_early_drop();
    test_fairness();
    test_decode_sweep();
    test_dwell1();
    if (q.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard_leftover got %0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
